// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: transmit sequencer state encoding, parity-sense
// constants and the legal parameter ranges checked by uart_tx_ctrl at
// elaboration.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    // Parity sense: value XORed into the reduction of the data word.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned DATA_BITS_MIN = 5;
    localparam int unsigned DATA_BITS_MAX = 9;
    localparam int unsigned STOP_BITS_MIN = 1;
    localparam int unsigned STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Transmit-side UART sequencer. Accepts one word per valid/ready handshake and
// serialises it onto txd as start, data (LSB first), optional parity and stop
// bits, one bit per baud_tick.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   baud_tick  in   one-cycle 1x baud enable
//   tx_data    in   word to send, sampled on accept
//   tx_valid   in   source has a word
//   tx_ready   out  controller can accept a word (registered)
//   txd        out  serial line, idles high (registered)
//   tx_busy    out  frame pending or in flight (registered, == ~tx_ready)
//   tx_done    out  one-cycle pulse after the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CntW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_BITS - 1);
    localparam logic [CntW-1:0] StopLast = CntW'(STOP_BITS - 1);
    localparam logic ParSense = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_ctrl: DATA_BITS out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_ctrl: STOP_BITS out of range");
    end

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        txd_d   = txd_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                // A tick coinciding with the accept is deliberately not seen:
                // ARM waits for the next one.
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    cnt_d   = '0;
                    par_d   = (^tx_data) ^ ParSense;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (baud_tick) begin
                    txd_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_tick) begin
                    // cnt_q counts data bits already held on the line.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q < DataLast) begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else if (PARITY_EN != 0) begin
                        txd_d   = par_q;
                        state_d = StParity;
                    end else begin
                        txd_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StStop;
                    end
                end
            end
            StParity: begin
                if (baud_tick) begin
                    txd_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                // Counter is reused to count stop bits.
                if (baud_tick) begin
                    if (cnt_q == StopLast) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = ready_q;
    assign txd      = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Four independent lanes, each with its own uart_tx_ctrl configuration:
//   lane 0: 8N1   lane 1: 5N2   lane 2: 8E1   lane 3: 8O2
// Each lane has a driver (directed words then random ones), a random baud
// tick source, and a monitor that checks the line against a frame model built
// from a queue of issued words.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic clk;
    int   checks;
    int   errors;
    int   lanes_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %0h expected %0h at %0t", lane, nm, act, exp, $time);
        end
    endtask

    // Expected line value after each successive tick of a frame: bit 0 is the
    // start bit, then data LSB first, then parity if enabled; all higher bits
    // are 1 so any number of stop bits reads high.
    function automatic logic [15:0] frame_bits(input logic [8:0] w, input int db,
                                               input int pen, input int podd);
        logic [15:0] b;
        logic        p;
        b    = '1;
        b[0] = 1'b0;
        p    = (podd != 0);
        for (int i = 0; i < db; i++) begin
            b[1 + i] = w[i];
            p        = p ^ w[i];
        end
        if (pen != 0) b[1 + db] = p;
        return b;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lane
        localparam int DB   = (g == 1) ? 5 : 8;
        localparam int PEN  = (g >= 2) ? 1 : 0;
        localparam int PODD = (g == 3) ? 1 : 0;
        localparam int SB   = (g == 1 || g == 3) ? 2 : 1;
        localparam int LEN  = 1 + DB + PEN + SB;

        logic          rst;
        logic          baud_tick;
        logic          force_tick;
        logic [DB-1:0] tx_data;
        logic          tx_valid;
        logic          tx_ready;
        logic          txd;
        logic          tx_busy;
        logic          tx_done;

        logic [8:0]    exp_q [$];
        int            m_phase;

        uart_tx_ctrl #(
            .DATA_BITS (DB),
            .PARITY_EN (PEN),
            .PARITY_ODD(PODD),
            .STOP_BITS (SB)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .baud_tick(baud_tick),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .txd      (txd),
            .tx_busy  (tx_busy),
            .tx_done  (tx_done)
        );

        // Baud enable: random, roughly one cycle in four, forceable.
        initial begin
            baud_tick = 1'b0;
            forever begin
                @(negedge clk);
                baud_tick = force_tick | ($urandom_range(0, 3) == 0);
            end
        end

        // Present a word and wait for it to be taken. With hold set, valid is
        // left high so the next send queues back-to-back.
        task automatic send(input logic [8:0] w, input bit hold);
            int n;
            @(negedge clk);
            tx_data  = w[DB-1:0];
            tx_valid = 1'b1;
            exp_q.push_back(w);
            n = 0;
            while (tx_ready !== 1'b1 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 3000) chk("accept_timeout", g, 32'(n), 32'(0));
            @(posedge clk);
            #1;
            if (!hold) begin
                @(negedge clk);
                tx_valid = 1'b0;
                tx_data  = DB'($urandom);
            end
        endtask

        // Driver
        initial begin
            int ticks;
            int n;
            rst        = 1'b1;
            tx_valid   = 1'b0;
            tx_data    = '0;
            force_tick = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);

            // Tick coincident with the accept must be ignored.
            @(posedge clk);
            #1;
            force_tick = 1'b1;
            send(9'h0A5, 1'b0);
            force_tick = 1'b0;

            send(9'h03C, 1'b1);
            send(9'h081, 1'b0);

            // Abandon a frame with reset while data bit 4 is on the line.
            send(9'h0FF, 1'b0);
            ticks = 0;
            n     = 0;
            while (ticks < 6 && n < 3000) begin
                #1;
                if (baud_tick) ticks++;
                @(negedge clk);
                n++;
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;

            send(9'h000, 1'b0);
            send(9'h01F, 1'b0);

            for (int i = 0; i < 24; i++) begin
                bit hold;
                hold = (i != 23) && ($urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(9'($urandom), hold);
            end

            n = 0;
            while (!(exp_q.size() == 0 && m_phase == 0) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            repeat (4) @(negedge clk);
            lanes_done++;
        end

        // Monitor / scoreboard. Phase 0 idle, 1 waiting for first tick,
        // 2 frame on the line with idx ticks elapsed since the start bit.
        initial begin
            logic        tk;
            logic        acc;
            logic        r;
            logic        done_exp;
            logic        exp_txd;
            logic [15:0] bits;
            logic [8:0]  w;
            int          idx;
            m_phase = 0;
            idx     = 0;
            bits    = '1;
            forever begin
                @(negedge clk);
                #1;
                tk  = baud_tick;
                acc = tx_valid && (m_phase == 0);
                r   = rst;
                @(posedge clk);
                #1;
                done_exp = 1'b0;
                if (r) begin
                    m_phase = 0;
                end else begin
                    case (m_phase)
                        0: begin
                            if (acc) begin
                                chk("queue_nonempty", g, 32'(exp_q.size() != 0), 32'(1));
                                if (exp_q.size() != 0) begin
                                    w    = exp_q.pop_front();
                                    bits = frame_bits(w, DB, PEN, PODD);
                                end
                                m_phase = 1;
                            end
                        end
                        1: begin
                            if (tk) begin
                                m_phase = 2;
                                idx     = 0;
                            end
                        end
                        default: begin
                            if (tk) begin
                                idx++;
                                if (idx == LEN) begin
                                    m_phase  = 0;
                                    done_exp = 1'b1;
                                end
                            end
                        end
                    endcase
                end
                exp_txd = (m_phase == 2) ? bits[idx] : 1'b1;
                chk("txd", g, 32'(txd), 32'(exp_txd));
                chk("tx_ready", g, 32'(tx_ready), 32'(m_phase == 0));
                chk("tx_busy", g, 32'(tx_busy), 32'(m_phase != 0));
                chk("tx_done", g, 32'(tx_done), 32'(done_exp));
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        lanes_done = 0;
        for (int c = 0; c < 60000 && lanes_done < 4; c++) @(posedge clk);
        if (lanes_done < 4) begin
            errors++;
            $display("FAIL watchdog: lanes finished %0d expected 4", lanes_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
